// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: access lengths, FSM encoding and alignment rule shared by mem_port_arbiter
package mem_arb_pkg;
   localparam logic [1:0] LEN_BYTE = 2'b01;
   localparam logic [1:0] LEN_HALF = 2'b10;
   localparam logic [1:0] LEN_WORD = 2'b11;
   typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_ACCESS, ST_RESP} state_t;
   function automatic logic misaligned(input logic [1:0] len, input logic [1:0] a);
      return len == 2'b00 || (len == LEN_HALF && a[0]) || (len == LEN_WORD && a != 2'b00);
   endfunction
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: 2-way grant picker; MEM_ARB_RR_EN selects round-robin, otherwise port 0 has fixed priority
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       gnt_idx
);
`ifdef MEM_ARB_RR_EN
   assign gnt_idx = &req ? ~last_grant : req[1];
`else
   logic unused_last;
   assign unused_last = last_grant;
   assign gnt_idx = req[1] & ~req[0];
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-port arbiter/sequencer for the 64 B big-endian data memory
// Tie policy lives in mem_arb_pick, selected by MEM_ARB_RR_EN (round-robin) or fixed priority when undefined
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int NREQ   = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ-1:0]        req_we,
   input  logic [2*NREQ-1:0]      req_length,
   input  logic [NREQ-1:0]        req_signed,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   input  logic [32*NREQ-1:0]     req_wdata,
   output logic [NREQ-1:0]        rsp_done,
   output logic [NREQ-1:0]        rsp_err,
   output logic [31:0]            rsp_rdata,
   output logic [1:0]             mem_length,
   output logic                   mem_signed,
   output logic [31:0]            address,
   output logic [31:0]            mem_write_data,
   output logic                   memread,
   output logic                   memwrite,
   input  logic [31:0]            mem_read_data
);
   state_t state;
   logic gnt_idx, last_grant, idx, we, sgn;
   logic [1:0] len;
   logic [ADDR_W-1:0] addr;
   logic [31:0] wdata;
   mem_arb_pick u_pick (.req(req_valid), .last_grant(last_grant), .gnt_idx(gnt_idx));
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
         last_grant <= 1'b1;
         idx <= 1'b0;
         we <= 1'b0;
         sgn <= 1'b0;
         len <= 2'b00;
         addr <= '0;
         wdata <= '0;
         rsp_done <= '0;
         rsp_err <= '0;
         rsp_rdata <= '0;
         mem_length <= 2'b00;
         mem_signed <= 1'b0;
         address <= '0;
         mem_write_data <= '0;
         memread <= 1'b0;
         memwrite <= 1'b0;
      end else begin
         rsp_done <= '0;
         rsp_err <= '0;
         case (state)
            ST_IDLE: if (|req_valid) begin
               idx <= gnt_idx;
               we <= req_we[gnt_idx];
               sgn <= req_signed[gnt_idx];
               len <= gnt_idx ? req_length[3:2] : req_length[1:0];
               addr <= gnt_idx ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
               wdata <= gnt_idx ? req_wdata[63:32] : req_wdata[31:0];
               state <= ST_CHECK;
            end
            ST_CHECK: if (misaligned(len, addr[1:0])) begin
               rsp_err[idx] <= 1'b1;
               state <= ST_RESP;
            end else begin
               mem_length <= len;
               mem_signed <= sgn;
               address <= 32'(addr);
               mem_write_data <= wdata;
               memwrite <= we;
               memread <= ~we;
               state <= ST_ACCESS;
            end
            // memory resolves the read combinationally and commits stores on the negedge of this cycle
            ST_ACCESS: begin
               memread <= 1'b0;
               memwrite <= 1'b0;
               if (!we) rsp_rdata <= mem_read_data;
               rsp_done[idx] <= 1'b1;
               state <= ST_RESP;
            end
            ST_RESP: begin
               last_grant <= idx;
               state <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table plus scoreboard bench for mem_port_arbiter with a 64 B big-endian memory
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;
   logic clock = 1'b0, reset = 1'b1, mem_clr = 1'b1;
   logic [1:0] req_valid = '0, req_we = '0, req_signed = '0;
   logic [3:0] req_length = '0;
   logic [63:0] req_addr = '0, req_wdata = '0;
   logic [1:0] rsp_done, rsp_err, mem_length;
   logic [31:0] rsp_rdata, address, mem_write_data, mem_read_data;
   logic mem_signed, memread, memwrite;
   logic [7:0] mem [64];
   logic [5:0] ma;
   int checks = 0, failures = 0;
   typedef struct { logic [1:0] done, err; logic [31:0] rdata; } rsp_t;
   typedef struct { logic p, we; logic [1:0] len; logic sgn; logic [31:0] a, wd; logic err; logic [31:0] rd; } vec_t;
   rsp_t exp_q[$];
   rsp_t got;
   vec_t v[14];

   mem_port_arbiter dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_length(req_length),
      .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_done(rsp_done),
      .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .mem_length(mem_length), .mem_signed(mem_signed),
      .address(address), .mem_write_data(mem_write_data), .memread(memread), .memwrite(memwrite),
      .mem_read_data(mem_read_data)
   );

   always #5 clock = ~clock;

   assign ma = address[5:0];
   always_comb
      mem_read_data = mem_length == LEN_BYTE ? {{24{mem_signed & mem[ma][7]}}, mem[ma]}
                    : mem_length == LEN_HALF ? {{16{mem_signed & mem[ma][7]}}, mem[ma], mem[ma+6'd1]}
                    : {mem[ma], mem[ma+6'd1], mem[ma+6'd2], mem[ma+6'd3]};

   always @(negedge clock) begin
      if (mem_clr) begin
         for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
      end else if (memwrite) begin
         if (mem_length == LEN_BYTE) mem[ma] <= mem_write_data[7:0];
         else if (mem_length == LEN_HALF) begin
            mem[ma] <= mem_write_data[15:8];
            mem[ma+6'd1] <= mem_write_data[7:0];
         end else begin
            mem[ma] <= mem_write_data[31:24];
            mem[ma+6'd1] <= mem_write_data[23:16];
            mem[ma+6'd2] <= mem_write_data[15:8];
            mem[ma+6'd3] <= mem_write_data[7:0];
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // scoreboard: every response pulse is matched against the oldest pending expectation
   always @(negedge clock) begin
      if (!reset && (|rsp_done || |rsp_err)) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp actual done=%b err=%b required none", rsp_done, rsp_err);
         end else begin
            got = exp_q.pop_front();
            check("rsp_done", {30'b0, rsp_done}, {30'b0, got.done});
            check("rsp_err", {30'b0, rsp_err}, {30'b0, got.err});
            if (|got.done) check("rsp_rdata", rsp_rdata, got.rdata);
         end
      end
   end

   task automatic issue(input logic p, input logic we, input logic [1:0] len, input logic sgn,
                        input logic [31:0] a, input logic [31:0] wd, input logic drop, input rsp_t e);
      int n, pi;
      logic acc;
      pi = int'(p);
      exp_q.push_back(e);
      req_valid[pi] = 1'b1;
      req_we[pi] = we;
      req_signed[pi] = sgn;
      req_length[2*pi +: 2] = len;
      req_addr[32*pi +: 32] = a;
      req_wdata[32*pi +: 32] = wd;
      n = 0;
      acc = 1'b0;
      do begin
         @(posedge clock);
         n++;
         @(negedge clock);
         acc |= memread | memwrite;
         if (n == 1 && drop) req_valid[pi] = 1'b0;
      end while (!(rsp_done[pi] | rsp_err[pi]) && n < 10);
      req_valid[pi] = 1'b0;
      check("latency", 32'(n), |e.err ? 32'd2 : 32'd3);
      if (|e.err) check("err_no_access", {31'b0, acc}, 32'd0);
      @(negedge clock);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rsp_t e;
      logic [31:0] last_rd;
      logic seen;
      int n;
      v[0]  = '{1'b0, 1'b1, LEN_WORD, 1'b0, 32'h08, 32'h11223344, 1'b0, 32'h0};
      v[1]  = '{1'b0, 1'b0, LEN_WORD, 1'b0, 32'h08, 32'h0, 1'b0, 32'h11223344};
      v[2]  = '{1'b0, 1'b1, LEN_BYTE, 1'b0, 32'h10, 32'h00000080, 1'b0, 32'h0};
      v[3]  = '{1'b0, 1'b0, LEN_BYTE, 1'b1, 32'h10, 32'h0, 1'b0, 32'hFFFFFF80};
      v[4]  = '{1'b0, 1'b0, LEN_BYTE, 1'b0, 32'h10, 32'h0, 1'b0, 32'h00000080};
      v[5]  = '{1'b0, 1'b1, LEN_HALF, 1'b0, 32'h12, 32'h00008001, 1'b0, 32'h0};
      v[6]  = '{1'b0, 1'b0, LEN_HALF, 1'b1, 32'h12, 32'h0, 1'b0, 32'hFFFF8001};
      v[7]  = '{1'b0, 1'b0, LEN_HALF, 1'b0, 32'h12, 32'h0, 1'b0, 32'h00008001};
      v[8]  = '{1'b0, 1'b1, LEN_WORD, 1'b0, 32'h06, 32'hDEADBEEF, 1'b1, 32'h0};
      v[9]  = '{1'b0, 1'b0, LEN_HALF, 1'b0, 32'h03, 32'h0, 1'b1, 32'h0};
      v[10] = '{1'b1, 1'b1, 2'b00, 1'b0, 32'h20, 32'hFFFFFFFF, 1'b1, 32'h0};
      v[11] = '{1'b1, 1'b0, LEN_WORD, 1'b0, 32'h08, 32'h0, 1'b0, 32'h11223344};
      v[12] = '{1'b1, 1'b1, LEN_WORD, 1'b0, 32'h3C, 32'hA5A5C3C3, 1'b0, 32'h0};
      v[13] = '{1'b1, 1'b0, LEN_HALF, 1'b0, 32'h3E, 32'h0, 1'b0, 32'h0000C3C3};
      last_rd = 32'h0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      mem_clr = 1'b0;
      check("reset_ctl", {23'b0, rsp_done, rsp_err, mem_length, mem_signed, memread, memwrite}, 32'd0);
      check("reset_address", address, 32'd0);
      check("reset_wdata", mem_write_data, 32'd0);
      check("reset_rdata", rsp_rdata, 32'd0);

      for (int i = 0; i < 14; i++) begin
         e.done = v[i].err ? 2'b00 : (v[i].p ? 2'b10 : 2'b01);
         e.err = v[i].err ? (v[i].p ? 2'b10 : 2'b01) : 2'b00;
         e.rdata = v[i].we ? last_rd : v[i].rd;
         if (!v[i].err && !v[i].we) last_rd = v[i].rd;
         issue(v[i].p, v[i].we, v[i].len, v[i].sgn, v[i].a, v[i].wd, 1'b0, e);
      end
      check("mem_after_err_store", {mem[6], mem[7], mem[8], mem[9]}, 32'h00001122);
      check("mem_after_len0_store", {mem[32], mem[33], mem[34], mem[35]}, 32'd0);

      // request withdrawn while in CHECK still completes, then the arbiter stays idle
      issue(1'b0, 1'b0, LEN_WORD, 1'b0, 32'h08, 32'h0, 1'b1, '{2'b01, 2'b00, 32'h11223344});
      seen = 1'b0;
      repeat (6) begin
         @(negedge clock);
         seen |= memread | memwrite;
      end
      check("idle_after_drop", {31'b0, seen}, 32'd0);

      // reset lands in ACCESS of a store, after its commit edge
      req_valid[0] = 1'b1;
      req_we[0] = 1'b1;
      req_length[1:0] = LEN_WORD;
      req_addr[31:0] = 32'h30;
      req_wdata[31:0] = 32'hCAFEBABE;
      n = 0;
      do begin
         @(posedge clock);
         n++;
         @(negedge clock);
      end while (!memwrite && n < 10);
      check("store_reached_access", 32'(n), 32'd2);
      reset = 1'b1;
      req_valid = '0;
      @(posedge clock);
      #1;
      check("rst_in_access_ctl", {23'b0, rsp_done, rsp_err, mem_length, mem_signed, memread, memwrite}, 32'd0);
      check("rst_in_access_addr", address, 32'd0);
      check("rst_in_access_rdata", rsp_rdata, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      check("store_committed", {mem[48], mem[49], mem[50], mem[51]}, 32'hCAFEBABE);
      seen = 1'b0;
      repeat (5) begin
         @(negedge clock);
         seen |= |rsp_done | |rsp_err;
      end
      check("no_rsp_after_reset", {31'b0, seen}, 32'd0);

      // both ports held: tie policy and 4-cycle issue interval
      req_we = 2'b00;
      req_signed = 2'b00;
      req_length = {LEN_WORD, LEN_WORD};
      req_addr = {32'h3C, 32'h08};
`ifdef MEM_ARB_RR_EN
      for (int k = 0; k < 4; k++)
         exp_q.push_back(k[0] ? '{2'b10, 2'b00, 32'hA5A5C3C3} : '{2'b01, 2'b00, 32'h11223344});
`else
      for (int k = 0; k < 4; k++) exp_q.push_back('{2'b01, 2'b00, 32'h11223344});
`endif
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         do begin
            @(posedge clock);
            n++;
            @(negedge clock);
         end while (!(|rsp_done) && n < 12);
         check("issue_interval", 32'(n), k == 0 ? 32'd3 : 32'd4);
      end
      req_valid = 2'b00;
      repeat (6) @(negedge clock);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
